// File: rtl/fsm_rd_0.sv
// fsm_rd_0: AXI4 read-side slave FSM for the offload engine.
// Serves read bursts from the varint output FIFO (0x00), the raw-data output
// FIFO (0xF0) or a non-destructive status word (0x80); any other address
// returns SLVERR beats. Each beat re-reads the same address.
// Optional feature macro: FSM_RD_TIMEOUT_EN. It bounds the wait for an empty
// FIFO to TIMEOUT_CYCLES cycles per beat and answers with SLVERR on expiry.
//
// state    | meaning
// INIT     | clear captured request and read data, then open the address channel
// AR_READY | arready high, waiting for a read request
// R_WAIT   | fetch the word for the current beat (FIFO pop / status / error)
// R_VALID  | rvalid high, payload held until rready
module fsm_rd_0 #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [3:0]  axs_s0_arid,
    input  logic [31:0] axs_s0_araddr,
    input  logic [7:0]  axs_s0_arlen,
    input  logic [2:0]  axs_s0_arsize,
    input  logic [1:0]  axs_s0_arburst,
    input  logic        axs_s0_arvalid,
    output logic        axs_s0_arready,

    output logic [3:0]  axs_s0_rid,
    output logic [31:0] axs_s0_rdata,
    output logic [1:0]  axs_s0_rresp,
    output logic        axs_s0_rlast,
    output logic        axs_s0_rvalid,
    input  logic        axs_s0_rready,

    input  logic        varint_out_fifo_empty,
    input  logic [31:0] varint_out_fifo_data,
    output logic        varint_out_fifo_pop,

    input  logic        raw_data_out_fifo_empty,
    input  logic [31:0] raw_data_out_fifo_data,
    output logic        raw_data_out_fifo_pop
);

    localparam logic [7:0] ADDR_VARINT = 8'h00;
    localparam logic [7:0] ADDR_RAW    = 8'hF0;
    localparam logic [7:0] ADDR_STATUS = 8'h80;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("fsm_rd_0: TIMEOUT_CYCLES must be within 1..65535");
        end
    endgenerate

    typedef enum logic [3:0] {
        INIT     = 4'b0001,
        AR_READY = 4'b0010,
        R_WAIT   = 4'b0100,
        R_VALID  = 4'b1000
    } state_t;

    state_t      state;
    logic [3:0]  id_q;
    logic [7:0]  addr_q;
    logic [7:0]  len_q;
    logic [7:0]  beat_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;

`ifdef FSM_RD_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;
`endif

    logic        sel_varint;
    logic        sel_raw;
    logic        sel_status;
    logic        sel_empty;
    logic [31:0] sel_data;
    logic        unused_bits;

    // Size/burst and the upper address bits carry no meaning for this slave.
    assign unused_bits = ^{size_q, burst_q, axs_s0_araddr[31:8]};

    // Target decode of the captured address.
    always_comb begin
        sel_varint = (addr_q == ADDR_VARINT);
        sel_raw    = (addr_q == ADDR_RAW);
        sel_status = (addr_q == ADDR_STATUS);
        sel_empty  = sel_varint ? varint_out_fifo_empty : raw_data_out_fifo_empty;
        sel_data   = sel_varint ? varint_out_fifo_data  : raw_data_out_fifo_data;
    end

    // Pops follow the FIFO's empty flag within the same cycle, so a word that
    // appears while waiting is consumed immediately; one R_WAIT visit is at
    // most one cycle long once data is there, which bounds pops to one per beat.
    assign varint_out_fifo_pop   = !reset && (state == R_WAIT) && sel_varint && !varint_out_fifo_empty;
    assign raw_data_out_fifo_pop = !reset && (state == R_WAIT) && sel_raw    && !raw_data_out_fifo_empty;

    assign axs_s0_rid = id_q;

    // Read FSM with registered channel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= INIT;
            axs_s0_arready <= 1'b0;
            axs_s0_rvalid  <= 1'b0;
            axs_s0_rlast   <= 1'b0;
            axs_s0_rdata   <= 32'h0;
            axs_s0_rresp   <= RESP_OKAY;
            id_q           <= 4'h0;
            addr_q         <= 8'h0;
            len_q          <= 8'h0;
            beat_q         <= 8'h0;
            size_q         <= 3'h0;
            burst_q        <= 2'h0;
`ifdef FSM_RD_TIMEOUT_EN
            wait_cnt       <= 16'h0;
`endif
        end else begin
            case (state)
                INIT: begin
                    id_q           <= 4'h0;
                    addr_q         <= 8'h0;
                    len_q          <= 8'h0;
                    beat_q         <= 8'h0;
                    axs_s0_rdata   <= 32'h0;
                    axs_s0_rresp   <= RESP_OKAY;
                    axs_s0_rlast   <= 1'b0;
                    axs_s0_rvalid  <= 1'b0;
                    axs_s0_arready <= 1'b1;
                    state          <= AR_READY;
                end
                AR_READY: begin
                    if (axs_s0_arvalid) begin
                        id_q           <= axs_s0_arid;
                        addr_q         <= axs_s0_araddr[7:0];
                        len_q          <= axs_s0_arlen;
                        size_q         <= axs_s0_arsize;
                        burst_q        <= axs_s0_arburst;
                        beat_q         <= 8'h0;
                        axs_s0_arready <= 1'b0;
`ifdef FSM_RD_TIMEOUT_EN
                        wait_cnt       <= 16'h0;
`endif
                        state          <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (sel_varint || sel_raw) begin
                        if (!sel_empty) begin
                            axs_s0_rdata  <= sel_data;
                            axs_s0_rresp  <= RESP_OKAY;
                            axs_s0_rlast  <= (beat_q == len_q);
                            axs_s0_rvalid <= 1'b1;
                            state         <= R_VALID;
                        end
`ifdef FSM_RD_TIMEOUT_EN
                        else if (wait_cnt == WAIT_LAST) begin
                            axs_s0_rdata  <= 32'h0;
                            axs_s0_rresp  <= RESP_SLVERR;
                            axs_s0_rlast  <= (beat_q == len_q);
                            axs_s0_rvalid <= 1'b1;
                            state         <= R_VALID;
                        end else begin
                            wait_cnt <= wait_cnt + 16'h1;
                        end
`endif
                    end else if (sel_status) begin
                        axs_s0_rdata  <= {30'h0, raw_data_out_fifo_empty, varint_out_fifo_empty};
                        axs_s0_rresp  <= RESP_OKAY;
                        axs_s0_rlast  <= (beat_q == len_q);
                        axs_s0_rvalid <= 1'b1;
                        state         <= R_VALID;
                    end else begin
                        axs_s0_rdata  <= 32'h0;
                        axs_s0_rresp  <= RESP_SLVERR;
                        axs_s0_rlast  <= (beat_q == len_q);
                        axs_s0_rvalid <= 1'b1;
                        state         <= R_VALID;
                    end
                end
                R_VALID: begin
                    if (axs_s0_rready) begin
                        axs_s0_rvalid <= 1'b0;
                        if (axs_s0_rlast) begin
                            axs_s0_arready <= 1'b1;
                            state          <= AR_READY;
                        end else begin
                            beat_q <= beat_q + 8'h1;
`ifdef FSM_RD_TIMEOUT_EN
                            wait_cnt <= 16'h0;
`endif
                            state  <= R_WAIT;
                        end
                    end
                end
                default: begin
                    axs_s0_arready <= 1'b0;
                    axs_s0_rvalid  <= 1'b0;
                    state          <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_rd_0.sv
// tb_fsm_rd_0: scoreboard bench for the AXI4 read-side FSM.
// FIFOs are modelled as queues; expected beats are derived from the address
// map and the queued words when each request is issued, and a monitor pops
// and compares them on every accepted R beat.
module tb_fsm_rd_0;

`ifdef FSM_RD_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        v_empty, r_empty, v_pop, r_pop;
    logic [31:0] v_data, r_data;

    always #5 clk = ~clk;

    fsm_rd_0 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .axs_s0_arid(arid), .axs_s0_araddr(araddr), .axs_s0_arlen(arlen),
        .axs_s0_arsize(arsize), .axs_s0_arburst(arburst),
        .axs_s0_arvalid(arvalid), .axs_s0_arready(arready),
        .axs_s0_rid(rid), .axs_s0_rdata(rdata), .axs_s0_rresp(rresp),
        .axs_s0_rlast(rlast), .axs_s0_rvalid(rvalid), .axs_s0_rready(rready),
        .varint_out_fifo_empty(v_empty), .varint_out_fifo_data(v_data),
        .varint_out_fifo_pop(v_pop),
        .raw_data_out_fifo_empty(r_empty), .raw_data_out_fifo_data(r_data),
        .raw_data_out_fifo_pop(r_pop)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t       sb[$];
    logic [31:0] vq[$], rq[$];     // words physically in the FIFOs
    logic [31:0] mvq[$], mrq[$];   // words the model still expects to be read
    int checks = 0, errors = 0;
    int cyc = 0;
    int vpops = 0, rpops = 0;
    int first_pop_cyc = -1, last_pop_cyc = -1, first_rv_cyc = -1;
    int rready_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // FIFO model: pops observed mid-cycle take effect just after the edge.
    initial begin
        logic pv, pr;
        v_empty = 1'b1; v_data = 32'h0;
        r_empty = 1'b1; r_data = 32'h0;
        forever begin
            @(negedge clk);
            pv = v_pop;
            pr = r_pop;
            if (pv) begin
                chk("varint_pop_when_empty", {31'h0, v_empty}, 32'h0);
                chk("dual_pop", {31'h0, r_pop}, 32'h0);
            end
            if (pr) chk("raw_pop_when_empty", {31'h0, r_empty}, 32'h0);
            if (pv || pr) begin
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (pv) begin vpops++; if (vq.size() > 0) void'(vq.pop_front()); end
            if (pr) begin rpops++; if (rq.size() > 0) void'(rq.pop_front()); end
            v_empty = (vq.size() == 0);
            v_data  = (vq.size() != 0) ? vq[0] : 32'h0;
            r_empty = (rq.size() == 0);
            r_data  = (rq.size() != 0) ? rq[0] : 32'h0;
        end
    end

    // rready pattern: 0 always high, 1 toggling, 2 random, 3 held low.
    initial begin
        rready = 1'b0;
        forever begin
            tick();
            case (rready_mode)
                0: rready = 1'b1;
                1: rready = ~rready;
                2: rready = 1'($urandom);
                default: rready = 1'b0;
            endcase
        end
    end

    // Monitor: payload stability while stalled, and scoreboard compare on accept.
    initial begin
        logic        prv, prr, plast;
        logic [31:0] pd;
        logic [1:0]  presp;
        logic [3:0]  pid;
        beat_t       e;
        prv = 1'b0; prr = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prv = 1'b0;
                continue;
            end
            if (rvalid && !prv && first_rv_cyc < 0) first_rv_cyc = cyc;
            if (prv && !prr) begin
                chk("rvalid_hold", {31'h0, rvalid}, 32'h1);
                chk("rdata_hold", rdata, pd);
                chk("rresp_hold", {30'h0, rresp}, {30'h0, presp});
                chk("rlast_hold", {31'h0, rlast}, {31'h0, plast});
                chk("rid_hold", {28'h0, rid}, {28'h0, pid});
            end
            if (rvalid && rready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", rdata);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rresp", {30'h0, rresp}, {30'h0, e.resp});
                    chk("rlast", {31'h0, rlast}, {31'h0, e.last});
                    chk("rid", {28'h0, rid}, {28'h0, e.id});
                end
            end
            prv = rvalid; prr = rready; pd = rdata; presp = rresp; plast = rlast; pid = rid;
        end
    end

    task automatic push_v(input logic [31:0] w);
        vq.push_back(w); mvq.push_back(w);
    endtask

    task automatic push_r(input logic [31:0] w);
        rq.push_back(w); mrq.push_back(w);
    endtask

    task automatic clear_fifos();
        vq.delete(); mvq.delete(); rq.delete(); mrq.delete();
    endtask

    // Expected beats from the address map, computed when the request is issued.
    task automatic build_expect(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        beat_t b;
        for (int i = 0; i <= int'(len); i++) begin
            b.id   = id;
            b.last = (i == int'(len));
            b.resp = 2'b00;
            case (addr[7:0])
                8'h00:   b.data = (mvq.size() > 0) ? mvq.pop_front() : 32'h0;
                8'hF0:   b.data = (mrq.size() > 0) ? mrq.pop_front() : 32'h0;
                8'h80:   b.data = {30'h0, rq.size() == 0, vq.size() == 0};
                default: begin b.data = 32'h0; b.resp = 2'b10; end
            endcase
            sb.push_back(b);
        end
    endtask

    task automatic ar_handshake(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                output int hs);
        bit ok;
        ok = 1'b0;
        hs = 0;
        tick();
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len;
        arsize = 3'($urandom); arburst = 2'($urandom);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (arready) begin hs = cyc; ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ar_handshake_timeout actual=arready_low required=arready_high");
        end
        tick();
        arvalid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL burst_timeout actual=%0d_beats_left required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_txn(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int hs;
        int exp_v, exp_r;
        exp_v = (addr[7:0] == 8'h00) ? int'(len) + 1 : 0;
        exp_r = (addr[7:0] == 8'hF0) ? int'(len) + 1 : 0;
        vpops = 0; rpops = 0; first_pop_cyc = -1; first_rv_cyc = -1;
        build_expect(id, addr, len);
        ar_handshake(id, addr, len, hs);
        wait_done();
        chk("rvalid_latency", 32'(first_rv_cyc - hs), 32'd2);
        if (exp_v + exp_r > 0) chk("pop_latency", 32'(first_pop_cyc - hs), 32'd1);
        chk("varint_pops", 32'(vpops), 32'(exp_v));
        chk("raw_pops", 32'(rpops), 32'(exp_r));
    endtask

    initial begin
        int hs;
        int rp;
        reset = 1'b1; arvalid = 1'b0; arid = 4'h0; araddr = 32'h0; arlen = 8'h0;
        arsize = 3'h0; arburst = 2'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", {31'h0, arready}, 32'h0);
        chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst_rlast", {31'h0, rlast}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rresp", {30'h0, rresp}, 32'h0);
        chk("rst_rid", {28'h0, rid}, 32'h0);
        chk("rst_pops", {30'h0, v_pop, r_pop}, 32'h0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("init_arready", {31'h0, arready}, 32'h0);
        @(negedge clk);
        chk("arready_after_release", {31'h0, arready}, 32'h1);

        // Two varint words, rready held high.
        rready_mode = 0;
        tick();
        push_v(32'h11111111); push_v(32'h22222222);
        run_txn(4'd5, 32'h0000_0000, 8'd1);

        // Raw FIFO burst with rready toggling.
        rready_mode = 1;
        tick();
        for (int i = 0; i < 4; i++) push_r(32'hA000_0000 + 32'(i));
        run_txn(4'd9, 32'h0000_00F0, 8'd3);

        // Status with both FIFOs empty, then unmapped address.
        rready_mode = 0;
        run_txn(4'd2, 32'h0000_0080, 8'd0);
        run_txn(4'd7, 32'h0000_0044, 8'd2);

        // Empty varint FIFO: late push, or timeout to SLVERR.
        vpops = 0; first_pop_cyc = -1; first_rv_cyc = -1;
`ifdef FSM_RD_TIMEOUT_EN
        begin
            beat_t b;
            b.data = 32'h0; b.resp = 2'b10; b.last = 1'b1; b.id = 4'd3;
            sb.push_back(b);
        end
        ar_handshake(4'd3, 32'h0, 8'd0, hs);
        wait_done();
        chk("timeout_rvalid_latency", 32'(first_rv_cyc - hs), 32'(TO + 1));
        chk("timeout_no_pop", 32'(vpops), 32'd0);
`else
        mvq.push_back(32'hDEADBEEF);
        build_expect(4'd3, 32'h0, 8'd0);
        ar_handshake(4'd3, 32'h0, 8'd0, hs);
        repeat (20) tick();
        chk("no_rvalid_while_empty", {31'h0, rvalid}, 32'h0);
        vq.push_back(32'hDEADBEEF);
        wait_done();
        chk("late_rvalid_after_pop", 32'(first_rv_cyc - last_pop_cyc), 32'd1);
        chk("late_pops", 32'(vpops), 32'd1);
`endif

        // Reset while stalled in R_VALID on beat 1 of a 4-beat raw burst.
        rready_mode = 3;
        tick();
        for (int i = 0; i < 4; i++) push_r(32'hB000_0000 + 32'(i));
        rpops = 0;
        build_expect(4'd4, 32'h0000_00F0, 8'd3);
        ar_handshake(4'd4, 32'h0000_00F0, 8'd3, hs);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (rvalid) begin seen = 1'b1; break; end
            end
            chk("reset_test_rvalid_seen", {31'h0, seen}, 32'h1);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("midrst_arready", {31'h0, arready}, 32'h0);
        chk("midrst_pops", {30'h0, v_pop, r_pop}, 32'h0);
        @(negedge clk);
        chk("midrst_arready_after", {31'h0, arready}, 32'h1);
        rp = rpops;
        repeat (5) @(negedge clk);
        chk("midrst_no_more_pops", 32'(rpops), 32'(rp));
        chk("midrst_total_pops", 32'(rpops), 32'd1);
        tick();
        sb.delete();
        clear_fifos();
        rready_mode = 0;
        repeat (2) tick();

        // Randomized bursts.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [7:0]  len;
            int          sel;
            sel = int'($urandom_range(0, 3));
            len = 8'($urandom_range(0, 7));
            a = $urandom;
            case (sel)
                0: a[7:0] = 8'h00;
                1: a[7:0] = 8'hF0;
                2: a[7:0] = 8'h80;
                default: begin
                    a[7:0] = 8'($urandom);
                    if (a[7:0] == 8'h00 || a[7:0] == 8'h80 || a[7:0] == 8'hF0) a[7:0] = 8'h5A;
                end
            endcase
            rready_mode = int'($urandom_range(0, 2));
            tick();
            if (sel == 0) begin
                for (int i = 0; i <= int'(len); i++) push_v($urandom);
            end else if (sel == 1) begin
                for (int i = 0; i <= int'(len); i++) push_r($urandom);
            end else begin
                for (int i = 0; i < int'($urandom_range(0, 2)); i++) push_v($urandom);
                for (int i = 0; i < int'($urandom_range(0, 2)); i++) push_r($urandom);
            end
            run_txn(4'($urandom), a, len);
            tick();
            clear_fifos();
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_rd_0.md
# fsm_rd_0

AXI4 read-side slave state machine for the offload engine: accepts read bursts on the `axs_s0_ar*` channel, pops result words from the varint output FIFO or the raw-data output FIFO selected by `araddr[7:0]`, and returns them beat by beat on the `axs_s0_r*` channel. It complements the write-side FSM that feeds the input FIFOs. It also exposes a non-destructive status word and signals SLVERR for unmapped addresses.

## Interface
- `TIMEOUT_CYCLES`, 1024: empty-FIFO wait limit per beat; used only with `FSM_RD_TIMEOUT_EN`, legal range 1..65535.
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `axs_s0_arid` in 4; `axs_s0_araddr` in 32; `axs_s0_arlen` in 8; `axs_s0_arsize` in 3; `axs_s0_arburst` in 2: read address.
- `axs_s0_arvalid` in 1; `axs_s0_arready` out 1.
- `axs_s0_rid` out 4; `axs_s0_rdata` out 32; `axs_s0_rresp` out 2; `axs_s0_rlast` out 1; `axs_s0_rvalid` out 1; `axs_s0_rready` in 1.
- `varint_out_fifo_empty` in 1; `varint_out_fifo_data` in 32; `varint_out_fifo_pop` out 1: show-ahead FIFO, data valid while not empty, pop advances.
- `raw_data_out_fifo_empty` in 1; `raw_data_out_fifo_data` in 32; `raw_data_out_fifo_pop` out 1: same protocol.

## Operation
- Address decode on `araddr[7:0]`: 0x00 varint FIFO, 0xF0 raw FIFO, 0x80 status; all others unmapped.
- `arsize`/`arburst` captured, ignored; every beat targets the same address.
- Burst = `arlen`+1 beats (1..256); 8-bit beat counter, no wrap beyond `arlen`.
- States (one-hot): INIT, AR_READY, R_WAIT, R_VALID.
- INIT: clear captured id/addr/len, beat counter, rdata; -> AR_READY.
- AR_READY: `arready`=1; on `arvalid` capture arid/araddr/arlen, beat=0 -> R_WAIT.
- R_WAIT: FIFO target: if not empty, register FIFO data into `rdata`, pulse that FIFO's pop for exactly this cycle, rresp=OKAY(00) -> R_VALID; if empty, stay. Status target: `rdata`={30'b0, raw_data_out_fifo_empty, varint_out_fifo_empty} sampled this cycle, no pop -> R_VALID. Unmapped: `rdata`=0, rresp=SLVERR(10), no pop -> R_VALID.
- R_VALID: `rvalid`=1, `rid`=captured id, `rlast`=(beat==arlen). Hold rdata/rresp/rlast stable until `rready`. On `rready`: if last -> AR_READY, else beat+1 -> R_WAIT.
- Never more than one pop per beat; never pop when selected FIFO empty; never pop the non-selected FIFO.

## Timing
- Reset values: arready 0, rvalid 0, rlast 0, rdata 0, rresp 00, rid 0, both pops 0; state INIT.
- Reset asserted mid-burst: next cycle INIT, rvalid/pops low, burst abandoned, no further pops.
- arready rises one cycle after reset release (INIT lasts 1 cycle).
- Address handshake cycle N -> first pop at N+1 (if not empty) -> rvalid at N+2.
- Beat throughput: one beat per 2 cycles minimum (R_WAIT + R_VALID); rready held high gives 2 cycles/beat.
- FIFO going non-empty at cycle M while in R_WAIT: pop at M, rvalid at M+1.
- arready is 0 outside AR_READY; no outstanding-transaction overlap.
- rready held low: rvalid and payload stay constant indefinitely.

## Configuration
- `FSM_RD_TIMEOUT_EN` defined: 16-bit wait counter in R_WAIT counts cycles with selected FIFO empty, cleared on entry to R_WAIT; on reaching `TIMEOUT_CYCLES` -> R_VALID with rdata=0, rresp=SLVERR, no pop; burst continues with next beat.
- Not defined: no counter; R_WAIT waits indefinitely for data, rresp never SLVERR for mapped FIFO addresses.

## Test plan
- Varint FIFO holds 0x11111111,0x22222222; read araddr 0x00 arlen=1 arid=5 -> two beats data in order, rid=5, rresp 00, rlast only on beat 2, two pop pulses.
- Raw FIFO holds 4 words, read 0xF0 arlen=3 with rready toggling 1/0 -> four beats, payload stable while rready low, exactly four pops, varint pop never asserted.
- Both FIFOs empty, read 0x80 arlen=0 -> one beat rdata 0x00000003, rresp 00, rlast 1, no pops.
- Read 0x44 arlen=2 -> three beats rdata 0, rresp 10, last on beat 3, no pops.
- Varint FIFO empty, read 0x00 arlen=0, push 0xDEADBEEF 20 cycles later -> pop same cycle data appears, rvalid next cycle; with `FSM_RD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8 and no push -> SLVERR beat after 8 empty cycles.
- Assert reset in R_VALID of beat 1 of arlen=3 burst -> rvalid 0 next cycle, no further pops, arready 1 one cycle after reset release.
